// File: rtl/sys_id_regs.sv
// AXI4-Lite register block: ID, VERSION, free-running UPTIME, CONTROL and a bank of scratch registers.
// Write and read channels are independent; all READY/VALID outputs are registered.
module sys_id_regs #(
  parameter logic [31:0] C_SYS_ID      = 32'h5359_5349,
  parameter logic [31:0] C_VERSION     = 32'h0002_0000,
  parameter int          C_NUM_SCRATCH = 4,
  parameter int          C_ADDR_WIDTH  = 6
) (
  input  logic                    ACLK,
  input  logic                    ARESETN,
  input  logic [C_ADDR_WIDTH-1:0] S_AXI_AWADDR,
  input  logic                    S_AXI_AWVALID,
  output logic                    S_AXI_AWREADY,
  input  logic [31:0]             S_AXI_WDATA,
  input  logic [3:0]              S_AXI_WSTRB,
  input  logic                    S_AXI_WVALID,
  output logic                    S_AXI_WREADY,
  output logic [1:0]              S_AXI_BRESP,
  output logic                    S_AXI_BVALID,
  input  logic                    S_AXI_BREADY,
  input  logic [C_ADDR_WIDTH-1:0] S_AXI_ARADDR,
  input  logic                    S_AXI_ARVALID,
  output logic                    S_AXI_ARREADY,
  output logic [31:0]             S_AXI_RDATA,
  output logic [1:0]              S_AXI_RRESP,
  output logic                    S_AXI_RVALID,
  input  logic                    S_AXI_RREADY
);

  localparam int         NUM_REGS    = 4 + C_NUM_SCRATCH;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic {W_IDLE, W_RESP} w_state_e;
  typedef enum logic {R_IDLE, R_DATA} r_state_e;

  w_state_e    w_state_q, w_state_d;
  r_state_e    r_state_q, r_state_d;
  logic        awready_q, awready_d;
  logic        bvalid_q, bvalid_d;
  logic [1:0]  bresp_q, bresp_d;
  logic        arready_q, arready_d;
  logic        rvalid_q, rvalid_d;
  logic [1:0]  rresp_q, rresp_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] uptime_q, uptime_d;
  logic        freeze_q, freeze_d;
  logic [31:0] scratch_q [C_NUM_SCRATCH];
  logic [31:0] scratch_d [C_NUM_SCRATCH];

  logic        wr_commit;
  logic        uptime_clr;
  int          wr_idx;
  int          rd_idx;
  logic [1:0]  wr_resp;
  logic [31:0] wr_mask;
  logic [31:0] rd_word;
  logic [1:0]  rd_resp;
  logic        unused_addr_lsbs;

  assign unused_addr_lsbs = ^{S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};
  assign wr_idx  = int'(S_AXI_AWADDR[C_ADDR_WIDTH-1:2]);
  assign rd_idx  = int'(S_AXI_ARADDR[C_ADDR_WIDTH-1:2]);
  assign wr_mask = {{8{S_AXI_WSTRB[3]}}, {8{S_AXI_WSTRB[2]}},
                    {8{S_AXI_WSTRB[1]}}, {8{S_AXI_WSTRB[0]}}};

  always_comb begin
    wr_resp = RESP_OKAY;
    if (wr_idx < 3)             wr_resp = RESP_SLVERR;
    else if (wr_idx >= NUM_REGS) wr_resp = RESP_DECERR;
  end

  // Write FSM: READY is raised only once both AW and W are presented, so the pair is taken together.
  always_comb begin
    w_state_d = w_state_q;
    awready_d = 1'b0;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    wr_commit = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        if (awready_q) begin
          if (S_AXI_AWVALID && S_AXI_WVALID) begin
            wr_commit = 1'b1;
            bvalid_d  = 1'b1;
            bresp_d   = wr_resp;
            w_state_d = W_RESP;
          end
        end else if (S_AXI_AWVALID && S_AXI_WVALID) begin
          awready_d = 1'b1;
        end
      end
      W_RESP: begin
        if (S_AXI_BREADY) begin
          bvalid_d  = 1'b0;
          w_state_d = W_IDLE;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    freeze_d   = freeze_q;
    uptime_clr = 1'b0;
    scratch_d  = scratch_q;
    if (wr_commit && (wr_idx == 3) && S_AXI_WSTRB[0]) begin
      freeze_d   = S_AXI_WDATA[1];
      uptime_clr = S_AXI_WDATA[0];
    end
    for (int k = 0; k < C_NUM_SCRATCH; k++) begin
      if (wr_commit && (wr_idx == k + 4)) begin
        scratch_d[k] = (scratch_q[k] & ~wr_mask) | (S_AXI_WDATA & wr_mask);
      end
    end
  end

  // Clear wins over freeze; freeze uses the current CONTROL value, not the one being written.
  always_comb begin
    uptime_d = uptime_q;
    if (uptime_clr)     uptime_d = '0;
    else if (!freeze_q) uptime_d = uptime_q + 32'd1;
  end

  always_comb begin
    rd_word = '0;
    rd_resp = RESP_OKAY;
    case (rd_idx)
      0:       rd_word = C_SYS_ID;
      1:       rd_word = C_VERSION;
      2:       rd_word = uptime_q;
      3:       rd_word = {30'd0, freeze_q, 1'b0};
      default: rd_word = '0;
    endcase
    for (int k = 0; k < C_NUM_SCRATCH; k++) begin
      if (rd_idx == k + 4) rd_word = scratch_q[k];
    end
    if (rd_idx >= NUM_REGS) begin
      rd_word = '0;
      rd_resp = RESP_DECERR;
    end
  end

  // Read data is sampled from the pre-update register values at the ARREADY edge.
  always_comb begin
    r_state_d = r_state_q;
    arready_d = 1'b0;
    rvalid_d  = rvalid_q;
    rresp_d   = rresp_q;
    rdata_d   = rdata_q;
    case (r_state_q)
      R_IDLE: begin
        if (arready_q) begin
          if (S_AXI_ARVALID) begin
            rvalid_d  = 1'b1;
            rresp_d   = rd_resp;
            rdata_d   = rd_word;
            r_state_d = R_DATA;
          end
        end else if (S_AXI_ARVALID) begin
          arready_d = 1'b1;
        end
      end
      R_DATA: begin
        if (S_AXI_RREADY) begin
          rvalid_d  = 1'b0;
          r_state_d = R_IDLE;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      w_state_q <= W_IDLE;
      awready_q <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= 2'b00;
    end else begin
      w_state_q <= w_state_d;
      awready_q <= awready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_state_q <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rresp_q   <= 2'b00;
      rdata_q   <= '0;
    end else begin
      r_state_q <= r_state_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rresp_q   <= rresp_d;
      rdata_q   <= rdata_d;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      uptime_q <= '0;
      freeze_q <= 1'b0;
      for (int k = 0; k < C_NUM_SCRATCH; k++) scratch_q[k] <= '0;
    end else begin
      uptime_q  <= uptime_d;
      freeze_q  <= freeze_d;
      scratch_q <= scratch_d;
    end
  end

  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = awready_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RRESP   = rresp_q;
  assign S_AXI_RDATA   = rdata_q;

endmodule

// File: tb/tb_sys_id_regs.sv
// Directed bench for sys_id_regs; expected responses go into a scoreboard queue when
// stimulus is driven and are popped when the DUT presents BVALID/RVALID.
module tb_sys_id_regs;

  localparam logic [31:0] SYS_ID  = 32'h5359_5349;
  localparam logic [31:0] VERSION = 32'h0002_0000;

  logic        ACLK = 1'b0;
  logic        ARESETN = 1'b0;
  logic [5:0]  awaddr = '0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b0;
  logic [5:0]  araddr = '0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready = 1'b0;

  int tests = 0;
  int fails = 0;
  logic [33:0] sb_q [$];

  always #5 ACLK = ~ACLK;

  sys_id_regs #(
    .C_SYS_ID(SYS_ID), .C_VERSION(VERSION), .C_NUM_SCRATCH(4), .C_ADDR_WIDTH(6)
  ) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready)
  );

  task automatic chk(input string tag, input logic [33:0] obs, input logic [33:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic sb_check(input string tag, input logic [33:0] obs);
    if (sb_q.size() == 0) begin
      tests++;
      fails++;
      $error("FAIL %s: observed %h expected <empty scoreboard>", tag, obs);
    end else begin
      chk(tag, obs, sb_q.pop_front());
    end
  endtask

  task automatic axi_write(input string tag, input logic [5:0] a, input logic [31:0] d,
                           input logic [3:0] s, input logic [1:0] exp_resp);
    int n;
    sb_q.push_back({exp_resp, 32'h0});
    @(posedge ACLK); #1;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
    n = 0;
    while (!awready && n < 20) begin @(negedge ACLK); n++; end
    chk({tag, "_awready"}, {33'd0, awready & wready}, 34'd1);
    @(posedge ACLK); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    n = 0;
    while (!bvalid && n < 20) begin @(negedge ACLK); n++; end
    sb_check({tag, "_bresp"}, {bresp, 32'h0});
    bready = 1'b1;
    @(posedge ACLK); #1;
    bready = 1'b0;
  endtask

  task automatic do_read(input logic [5:0] a, output logic [33:0] got);
    int n;
    @(posedge ACLK); #1;
    araddr = a; arvalid = 1'b1;
    n = 0;
    while (!arready && n < 20) begin @(negedge ACLK); n++; end
    @(posedge ACLK); #1;
    arvalid = 1'b0;
    n = 0;
    while (!rvalid && n < 20) begin @(negedge ACLK); n++; end
    got = {rresp, rdata};
    rready = 1'b1;
    @(posedge ACLK); #1;
    rready = 1'b0;
  endtask

  task automatic axi_read(input string tag, input logic [5:0] a,
                          input logic [1:0] exp_resp, input logic [31:0] exp_data);
    logic [33:0] got;
    sb_q.push_back({exp_resp, exp_data});
    do_read(a, got);
    sb_check(tag, got);
  endtask

  // Drives a write and a read in the same cycle and leaves both responses pending.
  task automatic start_both(input logic [5:0] wa, input logic [31:0] wd, input logic [5:0] ra);
    int n;
    @(posedge ACLK); #1;
    awaddr = wa; wdata = wd; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    araddr = ra; arvalid = 1'b1;
    n = 0;
    while (!(awready && arready) && n < 20) begin @(negedge ACLK); n++; end
    @(posedge ACLK); #1;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
  endtask

  initial begin
    logic [33:0] v1, v2;
    logic        seen;
    logic [1:0]  br0;

    #12;
    chk("rst_ready", {30'd0, awready, wready, arready, 1'b0}, 34'd0);
    chk("rst_valid", {32'd0, bvalid, rvalid}, 34'd0);
    chk("rst_resp_data", {rresp, rdata}, 34'd0);
    chk("rst_bresp", {32'd0, bresp}, 34'd0);
    @(negedge ACLK);
    ARESETN = 1'b1;

    axi_read("rd_id", 6'h00, 2'b00, SYS_ID);
    axi_read("rd_version", 6'h04, 2'b00, VERSION);
    axi_read("rd_scratch_rst", 6'h10, 2'b00, 32'h0);

    for (int i = 0; i < 4; i++) begin
      axi_write("wr_scratch", 6'(6'h10 + 4 * i), 32'(i + 1), 4'hF, 2'b00);
    end
    for (int i = 0; i < 4; i++) begin
      axi_read("rd_scratch", 6'(6'h10 + 4 * i), 2'b00, 32'(i + 1));
    end

    axi_write("wr_full", 6'h10, 32'hAABB_CCDD, 4'hF, 2'b00);
    axi_write("wr_strb", 6'h10, 32'h1122_3344, 4'b0101, 2'b00);
    axi_read("rd_strb", 6'h10, 2'b00, 32'hAA22_CC44);
    axi_write("wr_strb0", 6'h10, 32'hFFFF_FFFF, 4'b0000, 2'b00);
    axi_read("rd_strb0", 6'h13, 2'b00, 32'hAA22_CC44);

    axi_write("wr_id", 6'h00, 32'h1234_5678, 4'hF, 2'b10);
    axi_read("rd_id_again", 6'h00, 2'b00, SYS_ID);
    axi_write("wr_uptime", 6'h08, 32'h0, 4'hF, 2'b10);
    axi_read("rd_decerr", 6'h3C, 2'b11, 32'h0);
    axi_write("wr_decerr", 6'h20, 32'h5, 4'hF, 2'b11);

    do_read(6'h08, v1);
    repeat (5) @(posedge ACLK);
    do_read(6'h08, v2);
    chk("uptime_counts", {33'd0, v2[31:0] > v1[31:0]}, 34'd1);

    axi_write("wr_freeze", 6'h0C, 32'h2, 4'hF, 2'b00);
    axi_read("rd_control", 6'h0C, 2'b00, 32'h2);
    do_read(6'h08, v1);
    repeat (10) @(posedge ACLK);
    do_read(6'h08, v2);
    chk("uptime_frozen", v2, v1);
    axi_write("wr_clear", 6'h0C, 32'h1, 4'hF, 2'b00);
    do_read(6'h08, v1);
    chk("uptime_cleared", {33'd0, v1[31:0] < 32'd10}, 34'd1);
    axi_read("rd_control_clr", 6'h0C, 2'b00, 32'h0);

    // Concurrent write and read of the same register: read sees the old value.
    sb_q.push_back({2'b00, 32'h0});
    sb_q.push_back({2'b00, 32'h3});
    start_both(6'h18, 32'hDEAD_0003, 6'h18);
    sb_check("conc_bresp", {bresp, 32'h0});
    sb_check("conc_rdata", {rresp, rdata});
    bready = 1'b1; rready = 1'b1;
    @(posedge ACLK); #1;
    bready = 1'b0; rready = 1'b0;
    axi_read("rd_after_conc", 6'h18, 2'b00, 32'hDEAD_0003);

    // AW alone must not be accepted.
    @(posedge ACLK); #1;
    awaddr = 6'h14; wdata = 32'h77; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b0;
    seen = 1'b0;
    repeat (5) begin @(negedge ACLK); seen = seen | awready | wready; end
    chk("aw_alone", {33'd0, seen}, 34'd0);
    @(posedge ACLK); #1;
    wvalid = 1'b1;
    for (int n = 0; n < 20 && !awready; n++) @(negedge ACLK);
    chk("ready_together", {32'd0, awready, wready}, 34'd3);
    @(posedge ACLK); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    chk("bvalid_next", {32'd0, bvalid, awready}, 34'd2);
    br0 = bresp;
    seen = 1'b1;
    repeat (3) begin @(negedge ACLK); seen = seen & bvalid & (bresp === br0); end
    chk("bvalid_hold", {31'd0, seen, br0}, {31'd0, 1'b1, 2'b00});
    bready = 1'b1;
    @(posedge ACLK); #1;
    bready = 1'b0;
    chk("bvalid_drop", {33'd0, bvalid}, 34'd0);

    // Reset with both responses outstanding.
    start_both(6'h14, 32'h99, 6'h10);
    chk("pre_rst_valid", {32'd0, bvalid, rvalid}, 34'd3);
    @(negedge ACLK); #2;
    ARESETN = 1'b0;
    #1;
    chk("rst_async_valid", {32'd0, bvalid, rvalid}, 34'd0);
    chk("rst_async_data", {bresp, rdata}, 34'd0);
    repeat (2) @(negedge ACLK);
    ARESETN = 1'b1;
    axi_read("rd_scratch0_rst", 6'h10, 2'b00, 32'h0);
    axi_read("rd_scratch1_rst", 6'h14, 2'b00, 32'h0);
    axi_read("rd_scratch2_rst", 6'h18, 2'b00, 32'h0);

    chk("sb_empty", 34'(sb_q.size()), 34'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
